// File: rtl/alu_result_fifo.sv
// Small first-word-fall-through buffer for ALU results plus flags, with
// saturating counters for overflowed results and rejected push attempts.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      result,
  input  logic             zero,
  input  logic             cout,
  input  logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_zcv,
  output logic [3:0]       count,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  logic [34:0]      mem_q [DEPTH];
  logic [34:0]      head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             push, pop, drop;

  // Ready/valid come from occupancy only, so a full buffer never accepts
  // a push even when the head is being popped in the same cycle.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != 4'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign drop      = in_valid && !in_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = '0;
      drop_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + 4'(push) - 4'(pop);
      if (push && overflow && !(&ovf_q)) ovf_d = ovf_q + 1'b1;
      if (drop && !(&drop_q))            drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is never cleared; stale words are hidden by the out_valid gating.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= {result, zero, cout, overflow};
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_result = out_valid ? head[34:3] : 32'd0;
  assign out_zcv    = out_valid ? head[2:0]  : 3'd0;
  assign count      = count_q;
  assign ovf_count  = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered entries; legal values 2, 4, 8 only.
REQ-002 SHALL have parameter CNT_W, default 8, width of the statistics counters.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous flush of contents and counters.
REQ-006 SHALL have port in_valid  input  1  upstream ALU result valid this cycle.
REQ-007 SHALL have port in_ready  output  1  buffer can accept an entry this cycle.
REQ-008 SHALL have port result  input  32  ALU result word.
REQ-009 SHALL have ports zero, cout, overflow  input  1 each  ALU flags.
REQ-010 SHALL have port out_valid  output  1  head entry present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts head entry.
REQ-012 SHALL have port out_result  output  32  head entry result.
REQ-013 SHALL have port out_zcv  output  3  head entry flags {zero, cout, overflow}.
REQ-014 SHALL have port count  output  4  current occupancy, 0..DEPTH.
REQ-015 SHALL have port ovf_count  output  CNT_W  accepted entries with overflow=1.
REQ-016 SHALL have port drop_count  output  CNT_W  cycles with in_valid=1 while in_ready=0.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count != DEPTH), derived from registered state only, never from out_ready.
REQ-019 out_valid SHALL equal (count != 0), registered state only.
REQ-020 Head entry SHALL appear on out_result/out_zcv first-word-fall-through; push into empty buffer visible with out_valid=1 on the cycle after the push edge (latency 1, no combinational bypass).
REQ-021 out_result and out_zcv SHALL be 0 whenever out_valid=0.
REQ-022 out_result/out_zcv SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO.
REQ-024 Simultaneous push and pop with 0 < count < DEPTH: both pointers advance, count unchanged.
REQ-025 Full (count=DEPTH): push blocked even if a pop occurs in the same cycle; count decrements by 1.
REQ-026 Empty: out_ready ignored; count changes only by push.
REQ-027 ovf_count SHALL increment by 1 on each push with overflow=1; saturate at 2^CNT_W-1.
REQ-028 drop_count SHALL increment by 1 each cycle in_valid=1 and in_ready=0; saturate at 2^CNT_W-1; dropped data SHALL not alter contents.
REQ-029 clr=1 SHALL at next edge set count, pointers, ovf_count, drop_count to 0; clr overrides push, pop and counter increments in that cycle.
REQ-030 Storage contents need not be cleared; only visibility via out_valid matters.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock edge, force count=0, out_valid=0, in_ready=1, out_result=0, out_zcv=0, ovf_count=0, drop_count=0, pointers=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries; first edge after rst_n rises SHALL behave as from empty.
REQ-033 No output SHALL take an X value after reset at any time.

Verification
REQ-034 Reset, then push result=32'h0000_0005 zcv=3'b000, out_ready=0 -> next cycle out_valid=1, out_result=32'h0000_0005, count=1, held for 3 cycles.
REQ-035 Push 4 entries 32'h1,32'h2,32'h3,32'h4 with out_ready=0, then in_valid=1 for 2 more cycles -> count=4, in_ready=0, drop_count=2; then out_ready=1 -> pops 1,2,3,4 in order, out_valid=0 after 4th.
REQ-036 count=2, in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, pointers wrap, outputs in push order, no drops.
REQ-037 Push 3 entries with overflow=1 (e.g. 32'h8000_0000, zcv=3'b011) -> ovf_count=3; assert clr with in_valid=1 -> count=0, ovf_count=0, entry not stored.
REQ-038 count=3, drop_count=5, pull rst_n low between edges -> all outputs 0 and in_ready=1 before next edge; after release, single push -> count=1.
REQ-039 Hold in_valid=1 while full for 300 cycles (CNT_W=8) -> drop_count=255, no wrap.
